// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-flop line synchronizer, oversampled start-bit hunt, LSB-first shift-in.
// Define UART_RX_MAJORITY_EN for 3-sample majority voting per bit (decision one tick later).
module uart_receiver #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 i_CLK,
    input  logic                 i_RESET_N,
    input  logic                 i_CLK_ENABLE,
    input  logic                 i_RX,
    output logic [DATA_BITS-1:0] o_DATA_OUT,
    output logic                 o_DATA_VALID,
    output logic                 o_FRAME_ERROR,
    output logic                 o_RX_BUSY
);

    localparam int TCW = $clog2(OVERSAMPLE);
    localparam int IW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TCW-1:0] TC_S    = TCW'(OVERSAMPLE / 2);
    localparam logic [TCW-1:0] TC_LAST = TCW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0]  IDX_LAST = IW'(DATA_BITS - 1);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [TCW-1:0] TC_SM1 = TCW'(OVERSAMPLE / 2 - 1);
    localparam logic [TCW-1:0] TC_D   = TCW'(OVERSAMPLE / 2 + 1);
`else
    localparam logic [TCW-1:0] TC_D   = TCW'(OVERSAMPLE / 2);
`endif

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        RECOVER = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic                   rx_meta_q, rx_meta_d;
    logic                   rx_s_q, rx_s_d;
    logic [TCW-1:0]         tc_q, tc_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;
    logic                   busy_q, busy_d;
    logic                   at_d_s;
    logic                   at_last_s;
    logic                   bit_s;
`ifdef UART_RX_MAJORITY_EN
    logic                   m1_q, m1_d;
    logic                   m0_q, m0_d;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
`endif

    // Tick-qualified decode and the per-bit sampled value
    always_comb begin
        rx_meta_d = i_RX;
        rx_s_d    = rx_meta_q;
        at_d_s    = i_CLK_ENABLE && (tc_q == TC_D);
        at_last_s = i_CLK_ENABLE && (tc_q == TC_LAST);
`ifdef UART_RX_MAJORITY_EN
        bit_s     = maj3(m1_q, m0_q, rx_s_q);
`else
        bit_s     = rx_s_q;
`endif
    end

    // State register plus synchronizer; the synchronizer idles high like the line
    always_ff @(posedge i_CLK or negedge i_RESET_N) begin
        if (!i_RESET_N) begin
            state_q   <= IDLE;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            rx_meta_q <= rx_meta_d;
            rx_s_q    <= rx_s_d;
        end
    end

    // Next-state logic; every transition is gated by the oversample tick
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (i_CLK_ENABLE && !rx_s_q) begin
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (at_d_s && bit_s) begin
                    state_d = IDLE;
                end else if (at_last_s) begin
                    state_d = DATA;
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (at_last_s && (idx_q == IDX_LAST)) begin
                    state_d = STOP;
                end else begin
                    state_d = DATA;
                end
            end
            // Leave STOP at the decision tick so a following start edge is not missed
            STOP: begin
                if (at_d_s) begin
                    state_d = bit_s ? IDLE : RECOVER;
                end else begin
                    state_d = STOP;
                end
            end
            RECOVER: begin
                if (i_CLK_ENABLE && rx_s_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = RECOVER;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Counter, bit index and shift register updates
    always_comb begin
        tc_d    = tc_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        if (i_CLK_ENABLE) begin
            case (state_q)
                IDLE: begin
                    tc_d  = '0;
                    idx_d = '0;
                end
                START: begin
                    if (tc_q == TC_LAST) begin
                        tc_d  = '0;
                        idx_d = '0;
                    end else begin
                        tc_d = tc_q + TCW'(1);
                    end
                end
                DATA: begin
                    if (tc_q == TC_D) begin
                        shift_d = {bit_s, shift_q[DATA_BITS-1:1]};
                    end else begin
                        shift_d = shift_q;
                    end
                    if (tc_q == TC_LAST) begin
                        tc_d  = '0;
                        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
                    end else begin
                        tc_d = tc_q + TCW'(1);
                    end
                end
                STOP: begin
                    if (tc_q == TC_D) begin
                        tc_d = '0;
                    end else begin
                        tc_d = tc_q + TCW'(1);
                    end
                end
                RECOVER: tc_d = '0;
                default: begin
                    tc_d  = '0;
                    idx_d = '0;
                end
            endcase
        end else begin
            tc_d = tc_q;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // Capture the two early votes of the majority window
    always_comb begin
        m1_d = m1_q;
        m0_d = m0_q;
        if (i_CLK_ENABLE && (tc_q == TC_SM1)) begin
            m1_d = rx_s_q;
        end else begin
            m1_d = m1_q;
        end
        if (i_CLK_ENABLE && (tc_q == TC_S)) begin
            m0_d = rx_s_q;
        end else begin
            m0_d = m0_q;
        end
    end

    // Majority vote sample flops
    always_ff @(posedge i_CLK or negedge i_RESET_N) begin
        if (!i_RESET_N) begin
            m1_q <= 1'b1;
            m0_q <= 1'b1;
        end else begin
            m1_q <= m1_d;
            m0_q <= m0_d;
        end
    end
`else
    logic unused_s;
    assign unused_s = ^TC_S;
`endif

    // Output decode: pulses last one cycle since the stop decision is a single tick
    always_comb begin
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        data_d  = data_q;
        busy_d  = (state_q != IDLE);
        if ((state_q == STOP) && at_d_s) begin
            if (bit_s) begin
                valid_d = 1'b1;
                data_d  = shift_q;
            end else begin
                ferr_d  = 1'b1;
            end
        end else begin
            data_d = data_q;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge i_CLK or negedge i_RESET_N) begin
        if (!i_RESET_N) begin
            tc_q    <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            tc_q    <= tc_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    assign o_DATA_OUT    = data_q;
    assign o_DATA_VALID  = valid_q;
    assign o_FRAME_ERROR = ferr_q;
    assign o_RX_BUSY     = busy_q;

endmodule
